// File: rtl/psum_pkg.sv
// Shared types, widths and the operand extension helper for the partial-sum
// accumulator.
package psum_pkg;

    localparam int PSUM_W    = 18;
    localparam int COL_W     = 9;
    localparam int EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        STOPPING = 2'd2
    } psum_state_e;

    // Extend the low in_w bits of val to EXT_MAX_W bits, sign- or zero-filling
    // above bit in_w-1. Callers cast the result down to their lane width.
    function automatic logic [EXT_MAX_W-1:0] psum_extend(
        input logic [PSUM_W-1:0] val,
        input int                in_w,
        input logic              is_signed
    );
        logic [EXT_MAX_W-1:0] res;
        logic                 fill;
        res  = '0;
        fill = 1'b0;
        for (int i = 0; i < PSUM_W; i++) begin
            if (i < in_w) begin
                res[i] = val[i];
            end
            if (i == in_w - 1) begin
                fill = is_signed & val[i];
            end
        end
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i >= in_w) begin
                res[i] = fill;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_lane_add.sv
// One accumulation lane: extend the operand to W bits, add it to the running
// value and flag signed/unsigned overflow.
// Build option: PSUM_ACC_SAT_EN clamps the sum to the representable range on
// overflow instead of wrapping.
module psum_lane_add
    import psum_pkg::*;
#(
    parameter int W    = 32,
    parameter int IN_W = PSUM_W
) (
    input  logic [W-1:0]    acc_i,
    input  logic [IN_W-1:0] opnd_i,
    input  logic            sign_i,
    output logic [W-1:0]    sum_o,
    output logic            ovf_o
);

    if (IN_W > PSUM_W) begin : g_bad_in_w
        $error("psum_lane_add: IN_W must not exceed PSUM_W");
    end

    logic [W-1:0] opnd_ext;
    logic [W:0]   raw_sum;
    logic         uns_ovf;
    logic         sgn_ovf;

    // Extend, add with carry-out, detect overflow for the selected signedness.
    always_comb begin
        opnd_ext = W'(psum_extend(PSUM_W'(opnd_i), IN_W, sign_i));
        raw_sum  = {1'b0, acc_i} + {1'b0, opnd_ext};
        uns_ovf  = raw_sum[W];
        sgn_ovf  = (acc_i[W-1] == opnd_ext[W-1]) && (raw_sum[W-1] != acc_i[W-1]);
        ovf_o    = sign_i ? sgn_ovf : uns_ovf;
        sum_o    = raw_sum[W-1:0];
`ifdef PSUM_ACC_SAT_EN
        if (ovf_o) begin
            if (sign_i) begin
                // Signed overflow only happens when both operands share a sign.
                sum_o = acc_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                sum_o = '1;
            end
        end
`endif
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums a programmable number of 18-bit psums (or two
// independent 9-bit column sums) into one result held in a one-entry
// valid/ready output register.
// Build option: PSUM_ACC_SAT_EN selects saturating instead of wrapping adds.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not configured; psums refused; waits for cfg_load
// ACCUM    | accepting psums, emitting one result per group
// STOPPING | finishing the current group, then back to IDLE
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int LANE_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              cfg_split,
    input  logic              cfg_sign,
    input  logic              cfg_stop,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              ovf
);

    if (2 * LANE_W > ACC_W) begin : g_bad_lane_w
        $error("psum_accumulator: 2*LANE_W must not exceed ACC_W");
    end

    psum_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               split_q, split_d;
    logic               sign_q, sign_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LANE_W-1:0]  lane0_q, lane0_d;
    logic [LANE_W-1:0]  lane1_q, lane1_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               acc_valid_q, acc_valid_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   full_sum;
    logic [LANE_W-1:0]  lane0_sum;
    logic [LANE_W-1:0]  lane1_sum;
    logic               full_ovf;
    logic               lane0_ovf;
    logic               lane1_ovf;
    logic [ACC_W-1:0]   split_word;
    logic               last_beat;
    logic               beat_acc;
    logic               beat_ovf;
    logic               grp_done;

    psum_lane_add #(.W(ACC_W), .IN_W(PSUM_W)) u_full (
        .acc_i  (acc_q),
        .opnd_i (psum_in),
        .sign_i (sign_q),
        .sum_o  (full_sum),
        .ovf_o  (full_ovf)
    );

    psum_lane_add #(.W(LANE_W), .IN_W(COL_W)) u_lane0 (
        .acc_i  (lane0_q),
        .opnd_i (psum_in[COL_W-1:0]),
        .sign_i (sign_q),
        .sum_o  (lane0_sum),
        .ovf_o  (lane0_ovf)
    );

    psum_lane_add #(.W(LANE_W), .IN_W(COL_W)) u_lane1 (
        .acc_i  (lane1_q),
        .opnd_i (psum_in[PSUM_W-1:COL_W]),
        .sign_i (sign_q),
        .sum_o  (lane1_sum),
        .ovf_o  (lane1_ovf)
    );

    // Handshake qualifiers; only the final beat of a group waits on a full output register.
    always_comb begin
        busy       = (state_q != IDLE);
        last_beat  = (cnt_q == (len_q - CNT_W'(1)));
        psum_ready = busy && !(last_beat && acc_valid_q && !acc_ready);
        beat_acc   = psum_valid && psum_ready;
        beat_ovf   = split_q ? (lane0_ovf | lane1_ovf) : full_ovf;
        grp_done   = beat_acc && last_beat;
        split_word = '0;
        split_word[2*LANE_W-1:0] = {lane1_sum, lane0_sum};
    end

    // Next-state, accumulation and output-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        split_d     = split_q;
        sign_d      = sign_q;
        acc_d       = acc_q;
        lane0_d     = lane0_q;
        lane1_d     = lane1_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        ovf_d       = ovf_q;

        if (acc_valid_q && acc_ready) begin
            acc_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    len_d   = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
                    split_d = cfg_split;
                    sign_d  = cfg_sign;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lane0_d = '0;
                    lane1_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM, STOPPING: begin
                if (beat_acc) begin
                    ovf_d = ovf_q | beat_ovf;
                    if (last_beat) begin
                        // Result leaves with this beat; the next group starts from zero
                        // on the very next cycle.
                        acc_out_d   = split_q ? split_word : full_sum;
                        acc_valid_d = 1'b1;
                        cnt_d       = '0;
                        acc_d       = '0;
                        lane0_d     = '0;
                        lane1_d     = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        acc_d   = full_sum;
                        lane0_d = lane0_sum;
                        lane1_d = lane1_sum;
                    end
                end
                if (state_q == ACCUM) begin
                    if (cfg_stop) begin
                        if (grp_done || (cnt_q == '0 && !beat_acc)) begin
                            state_d = IDLE;
                        end else begin
                            state_d = STOPPING;
                        end
                    end
                end else if (grp_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            split_q     <= 1'b0;
            sign_q      <= 1'b0;
            acc_q       <= '0;
            lane0_q     <= '0;
            lane1_q     <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            split_q     <= split_d;
            sign_q      <= sign_d;
            acc_q       <= acc_d;
            lane0_q     <= lane0_d;
            lane1_q     <= lane1_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: expected group results are queued
// as beats are driven and compared when the output handshake completes.
module tb_psum_accumulator;

    localparam int ACC_W  = 32;
    localparam int LANE_W = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_load;
    logic [CNT_W-1:0]  cfg_len;
    logic              cfg_split;
    logic              cfg_sign;
    logic              cfg_stop;
    logic [17:0]       psum_in;
    logic              psum_valid;
    logic              psum_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic              busy;
    logic              ovf;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [17:0] bq[$];
    bit          model_ovf;

    psum_accumulator #(.ACC_W(ACC_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_len    (cfg_len),
        .cfg_split  (cfg_split),
        .cfg_sign   (cfg_sign),
        .cfg_stop   (cfg_stop),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference add on a w-bit accumulator with an in_w-bit operand.
    task automatic model_add(inout logic [31:0] acc, input logic [17:0] raw,
                             input int in_w, input int w, input bit sgn);
        longint mask, a, b, s, maxv, minv;
        mask = (longint'(1) << w) - 1;
        a = longint'(acc) & mask;
        b = longint'(raw) & ((longint'(1) << in_w) - 1);
        if (sgn) begin
            if (a >= (longint'(1) << (w - 1)))    a = a - (longint'(1) << w);
            if (b >= (longint'(1) << (in_w - 1))) b = b - (longint'(1) << in_w);
            maxv = (longint'(1) << (w - 1)) - 1;
            minv = -(longint'(1) << (w - 1));
        end else begin
            maxv = mask;
            minv = 0;
        end
        s = a + b;
        if (s > maxv || s < minv) begin
            model_ovf = 1'b1;
`ifdef PSUM_ACC_SAT_EN
            s = (s > maxv) ? maxv : minv;
`endif
        end
        acc = 32'(s & mask);
    endtask

    // Queue the expected result of one group made of the beats in bq.
    task automatic push_group(input bit split, input bit sgn);
        logic [31:0] acc, l0, l1;
        acc = '0; l0 = '0; l1 = '0;
        foreach (bq[i]) begin
            if (split) begin
                model_add(l0, {9'b0, bq[i][8:0]},  9, LANE_W, sgn);
                model_add(l1, {9'b0, bq[i][17:9]}, 9, LANE_W, sgn);
            end else begin
                model_add(acc, bq[i], 18, ACC_W, sgn);
            end
        end
        sb_q.push_back(split ? {l1[15:0], l0[15:0]} : acc);
    endtask

    task automatic send_beat(input logic [17:0] v);
        int n;
        bit taken;
        n = 0;
        taken = 1'b0;
        psum_valid = 1'b1;
        psum_in    = v;
        while (!taken && n < 50) begin
            @(negedge clk);
            taken = psum_ready;
            @(posedge clk);
            #1;
            n++;
        end
        psum_valid = 1'b0;
        check_eq("beat_accept", 64'(taken), 1);
    endtask

    task automatic run_group(input bit split, input bit sgn);
        push_group(split, sgn);
        foreach (bq[i]) send_beat(bq[i]);
    endtask

    task automatic do_cfg(input logic [CNT_W-1:0] len, input bit split, input bit sgn);
        cfg_len   = len;
        cfg_split = split;
        cfg_sign  = sgn;
        cfg_load  = 1'b1;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        model_ovf = 1'b0;
    endtask

    task automatic do_stop();
        cfg_stop = 1'b1;
        @(posedge clk);
        #1;
        cfg_stop = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("sb_drain", 64'(sb_q.size()), 0);
    endtask

    // Output monitor: a completed handshake pops and compares one expected result.
    always @(negedge clk) begin
        if (!reset && acc_valid && acc_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_out", 64'(acc_valid), 0);
            end else begin
                check_eq("acc_out", 64'(acc_out), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_len = '0; cfg_split = 1'b0; cfg_sign = 1'b0;
        cfg_stop = 1'b0; psum_in = '0; psum_valid = 1'b0; acc_ready = 1'b1; model_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_psum_ready", 64'(psum_ready), 0);
        check_eq("rst_busy",       64'(busy), 0);
        check_eq("rst_acc_valid",  64'(acc_valid), 0);
        check_eq("rst_acc_out",    64'(acc_out), 0);
        check_eq("rst_ovf",        64'(ovf), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full unsigned, four beats; result visible right after the last beat, for one cycle.
        do_cfg(4, 1'b0, 1'b0);
        check_eq("cfg_busy", 64'(busy), 1);
        bq = '{18'd1, 18'd2, 18'd3, 18'd4};
        run_group(1'b0, 1'b0);
        check_eq("lat_valid", 64'(acc_valid), 1);
        @(posedge clk);
        #1;
        check_eq("valid_pulse", 64'(acc_valid), 0);
        check_eq("ovf_clean", 64'(ovf), 64'(model_ovf));
        do_stop();
        check_eq("stop_cnt0_idle", 64'(busy), 0);

        // Full signed vs unsigned on the same beats.
        do_cfg(2, 1'b0, 1'b1);
        bq = '{18'h3FFFF, 18'h00005};
        run_group(1'b0, 1'b1);
        do_stop();
        do_cfg(2, 1'b0, 1'b0);
        run_group(1'b0, 1'b0);
        do_stop();

        // Split signed: lanes accumulate independently.
        do_cfg(2, 1'b1, 1'b1);
        bq = '{18'h3FE03, 18'h3FE03};
        run_group(1'b1, 1'b1);
        wait_drain();
        do_stop();

        // Length 0 behaves as 1.
        do_cfg(0, 1'b0, 1'b0);
        bq = '{18'd7};
        run_group(1'b0, 1'b0);
        do_stop();

        // Backpressure with length 1: second beat stalls while result 1 is held.
        do_cfg(1, 1'b0, 1'b0);
        acc_ready = 1'b0;
        bq = '{18'd1}; push_group(1'b0, 1'b0);
        bq = '{18'd2}; push_group(1'b0, 1'b0);
        bq = '{18'd3}; push_group(1'b0, 1'b0);
        send_beat(18'd1);
        psum_valid = 1'b1;
        psum_in    = 18'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_ready_low", 64'(psum_ready), 0);
            check_eq("bp_hold_out",  64'(acc_out), 1);
        end
        @(posedge clk);
        #1;
        acc_ready = 1'b1;
        send_beat(18'd2);
        send_beat(18'd3);
        wait_drain();
        do_stop();

        // Full output register stalls only the last beat of the next group.
        do_cfg(2, 1'b0, 1'b0);
        acc_ready = 1'b0;
        bq = '{18'd1, 18'd1};
        run_group(1'b0, 1'b0);
        bq = '{18'd4, 18'd5};
        push_group(1'b0, 1'b0);
        send_beat(18'd4);
        psum_valid = 1'b1;
        psum_in    = 18'd5;
        @(negedge clk);
        check_eq("stall_last_ready", 64'(psum_ready), 0);
        @(posedge clk);
        #1;
        acc_ready = 1'b1;
        send_beat(18'd5);
        wait_drain();
        do_stop();

        // Stop after the first beat of three: group completes, then idle.
        do_cfg(3, 1'b0, 1'b0);
        bq = '{18'd5, 18'd6, 18'd7};
        push_group(1'b0, 1'b0);
        send_beat(18'd5);
        do_stop();
        check_eq("stopping_busy", 64'(busy), 1);
        send_beat(18'd6);
        send_beat(18'd7);
        check_eq("stop_done_idle", 64'(busy), 0);
        wait_drain();

        // Stop coincident with the last beat: result emitted, straight to idle.
        do_cfg(2, 1'b0, 1'b1);
        bq = '{18'd10, 18'd20};
        push_group(1'b0, 1'b1);
        send_beat(18'd10);
        cfg_stop = 1'b1;
        send_beat(18'd20);
        cfg_stop = 1'b0;
        check_eq("stop_last_idle", 64'(busy), 0);
        wait_drain();

        // Split unsigned overflow: 200 beats of 511 per lane exceed 16 bits.
        do_cfg(200, 1'b1, 1'b0);
        bq.delete();
        for (int i = 0; i < 200; i++) bq.push_back(18'h3FFFF);
        run_group(1'b1, 1'b0);
        wait_drain();
        check_eq("ovf_model", 64'(ovf), 64'(model_ovf));
        check_eq("ovf_set",   64'(ovf), 1);
        do_stop();
        do_cfg(1, 1'b0, 1'b0);
        check_eq("ovf_cleared", 64'(ovf), 0);

        // Reset with a pending output and an active configuration.
        acc_ready = 1'b0;
        send_beat(18'd9);
        check_eq("pre_rst_valid", 64'(acc_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_rst_acc_out",    64'(acc_out), 0);
        check_eq("mid_rst_acc_valid",  64'(acc_valid), 0);
        check_eq("mid_rst_busy",       64'(busy), 0);
        check_eq("mid_rst_psum_ready", 64'(psum_ready), 0);
        check_eq("mid_rst_ovf",        64'(ovf), 0);
        acc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_final_empty", 64'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
